fft_bitrev_reorder: RTL
=======================

// Module: fft_bitrev_reorder
// PURPOSE
//  Parametrised ping-pong reorder buffer behind the radix-2 FFT core. Accepts
//  complex samples in bit-reversed order (one per accepted beat) and emits each
//  frame in natural order 0..N-1, real and imaginary in parallel.
//  Two N-entry banks: one fills while the other drains, so 1 sample/clk is
//  sustained. Valid/ready on both sides; per-frame bypass mode; frame-sync check.
// PARAMETERS
//  DATA_W  17  width of each real/imag component (two's complement)
//  LOG2N   5   log2 of FFT length; N = 2**LOG2N (range 2..10)
// PORTS
//  clk        in   1       sole clock, all state on rising edge
//  rst        in   1       reset, synchronous, active-high
//  in_valid   in   1       input sample valid
//  in_ready   out  1       buffer can accept; registered, no comb path from out_ready
//  in_r       in   DATA_W  input real part
//  in_i       in   DATA_W  input imaginary part
//  in_last    in   1       producer's end-of-frame marker (checked only)
//  bypass     in   1       1: frame emitted in arrival order; sampled on first beat
//  out_valid  out  1       output sample valid
//  out_ready  in   1       consumer accepts output
//  out_r      out  DATA_W  output real part
//  out_i      out  DATA_W  output imaginary part
//  out_idx    out  LOG2N   natural-order index of out_r/out_i
//  out_last   out  1       high with out_idx == N-1
//  err_sync   out  1       1-clk pulse on frame-sync mismatch
// BEHAVIOUR
//  - Reset: wr_bank=0, rd_bank=0, both bank-full flags 0, counters 0;
//    in_ready=1, out_valid=0, out_last=0, err_sync=0, out_idx=0. Data regs unreset.
//  - Reset mid-frame discards all partial and full frames; out_valid drops next clk.
//  - Accept beat: in_valid & in_ready. Write addr = bypass_lat ? wr_cnt :
//    bitrev(wr_cnt), LOG2N bits. wr_cnt increments per beat, wraps N-1 -> 0.
//  - bypass is latched into bypass_lat[wr_bank] on the beat with wr_cnt==0; held for frame.
//  - Beat with wr_cnt==N-1: full[wr_bank]<=1, wr_bank toggles.
//  - in_ready = !full[wr_bank] (registered state only). Both banks full -> in_ready=0.
//  - Read side: out_valid = full[rd_bank]; out_r/out_i = bank[rd_bank][rd_cnt];
//    out_idx = rd_cnt; out_last = out_valid & (rd_cnt==N-1).
//  - Output beat: out_valid & out_ready; rd_cnt increments, wraps N-1 -> 0.
//    On out_last beat: full[rd_bank]<=0, rd_bank toggles.
//  - Output data stable while out_valid & !out_ready.
//  - Latency: last input beat at edge t -> out_valid=1, out_idx=0 from edge t+1.
//  - Simultaneous bank-complete (writer) and bank-release (reader) on same edge
//    act on different banks; both take effect. Released bank shows in_ready=1
//    one clk later (no same-cycle reuse).
//  - err_sync pulses the clk after an accepted beat where in_last != (wr_cnt==N-1).
//    Framing stays count-based; the error never alters counters or data.
//  - No arithmetic on data; values passed bit-exact, widths unchanged.
// TESTING  (LOG2N=5, DATA_W=17; sample k: in_r=k, in_i=-k; in_last on k=31)
//  1 One frame, bypass=0, out_ready=1 -> 32 beats, out_r by idx 0,1,2,3,31 =
//    0,16,8,24,31; out_i = -out_r; out_last only at idx 31; err_sync never 1.
//  2 Three frames back-to-back, in_valid=1, out_ready=1 -> in_ready stays 1
//    after reset, out_valid continuous from clk 33 for 96 beats, no gaps.
//  3 out_ready=0 for 70 clk -> in_ready falls after beat 64, out_r holds 0 at
//    idx 0; release -> both frames drain intact in order.
//  4 Frame 1 bypass=1, frame 2 bypass=0 -> frame 1 out_r = idx (0,1,2..);
//    frame 2 out_r at idx 1 = 16; toggling bypass mid-frame has no effect.
//  5 in_last at k=20 and missing at k=31 -> err_sync pulses twice, output
//    frame still 32 beats with bit-reversed data.
//  6 rst=1 for one clk at k=17, restart frame -> out_valid=0, in_ready=1 next
//    clk; first output frame is the restarted one only.

Source files
------------

// File: rtl/fft_bitrev_reorder_if.sv
// Sample-in / sample-out handshake bundle for the FFT bit-reverse reorder buffer.
interface fft_bitrev_reorder_if #(
  parameter int DATA_W = 17,
  parameter int LOG2N  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_r;
  logic [DATA_W-1:0] in_i;
  logic              in_last;
  logic              bypass;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_r;
  logic [DATA_W-1:0] out_i;
  logic [LOG2N-1:0]  out_idx;
  logic              out_last;
  logic              err_sync;

  modport master (
    output in_valid, in_r, in_i, in_last, bypass, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_idx, out_last, err_sync
  );

  modport slave (
    input  in_valid, in_r, in_i, in_last, bypass, out_ready,
    output in_ready, out_valid, out_r, out_i, out_idx, out_last, err_sync
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: frames arrive bit-reversed, leave in natural order.
// One bank fills while the other drains, sustaining one sample per clock.
module fft_bitrev_reorder #(
  parameter int DATA_W = 17,
  parameter int LOG2N  = 5
) (
  input  logic                clk,
  input  logic                rst,
  fft_bitrev_reorder_if.slave bus
);
  localparam int N = 1 << LOG2N;
  typedef logic [LOG2N-1:0] idx_t;
  localparam idx_t LAST = idx_t'(N - 1);

  function automatic idx_t bitrev(input idx_t a);
    idx_t r;
    r = '0;
    for (int b = 0; b < LOG2N; b++) r[b] = a[LOG2N-1-b];
    return r;
  endfunction

  logic [DATA_W-1:0] mem_r [2*N];
  logic [DATA_W-1:0] mem_i [2*N];

  logic       wr_bank, rd_bank;
  logic [1:0] full, bypass_lat;
  idx_t       wr_cnt, rd_cnt;
  logic       err_q;

  logic wr_fire, rd_fire, byp_eff;
  idx_t wr_addr;

  assign wr_fire = bus.in_valid & bus.in_ready;
  assign rd_fire = bus.out_valid & bus.out_ready;

  // First beat of a frame uses the live bypass input; the latch is not yet written.
  always_comb begin
    byp_eff = bypass_lat[wr_bank];
    if (wr_cnt == '0) byp_eff = bus.bypass;
    wr_addr = byp_eff ? wr_cnt : bitrev(wr_cnt);
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_r[{wr_bank, wr_addr}] <= bus.in_r;
      mem_i[{wr_bank, wr_addr}] <= bus.in_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      full       <= 2'b00;
      bypass_lat <= 2'b00;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= wr_fire && (bus.in_last != (wr_cnt == LAST));
      if (wr_fire) begin
        wr_cnt <= wr_cnt + idx_t'(1);
        if (wr_cnt == '0) bypass_lat[wr_bank] <= bus.bypass;
        if (wr_cnt == LAST) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      // Writer only completes an empty bank and reader only releases a full one,
      // so these two updates never touch the same bit of full.
      if (rd_fire) begin
        rd_cnt <= rd_cnt + idx_t'(1);
        if (rd_cnt == LAST) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

  assign bus.in_ready  = ~full[wr_bank];
  assign bus.out_valid = full[rd_bank];
  assign bus.out_r     = mem_r[{rd_bank, rd_cnt}];
  assign bus.out_i     = mem_i[{rd_bank, rd_cnt}];
  assign bus.out_idx   = rd_cnt;
  assign bus.out_last  = full[rd_bank] & (rd_cnt == LAST);
  assign bus.err_sync  = err_q;
endmodule
